// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_e;

    // Field values the DOF/EX register takes when a bubble is injected
    localparam logic       RW_NOP = 1'b0;
    localparam logic       MW_NOP = 1'b0;
    localparam logic [1:0] BS_NOP = 2'b00;

    localparam int unsigned DEF_CNT_W = 16;
    localparam int unsigned RUN_CNT_W = 4;
    localparam int unsigned PEN_W     = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !(&cnt_q)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard stall / branch squash controller with Mealy outputs on dhs and b_d.
// Optional performance counters are built when PERF_CNT_EN is defined.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned BR_PENALTY = 1,
    parameter int unsigned MAX_STALL  = 4,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dhs,
    input  logic             b_d,
    output logic             pc_en,
    output logic             ir_en,
    output logic             bubble,
    output logic             flush,
    output logic             stall_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e               state_q, state_d;
    logic [PEN_W-1:0]     pen_q, pen_d;
    logic [RUN_CNT_W-1:0] run_q, run_inc;
    logic                 run_en, run_clr;
    logic                 err_q, err_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pen_q   <= '0;
        end else begin
            state_q <= state_d;
            pen_q   <= pen_d;
        end
    end

    // A hazard (dhs=0) always holds the branch in DOF, so b_d only matters with dhs=1
    always_comb begin
        state_d = state_q;
        pen_d   = pen_q;
        case (state_q)
            RUN: begin
                if (!dhs) begin
                    state_d = STALL;
                end else if (!b_d) begin
                    state_d = FLUSH;
                    pen_d   = PEN_W'(BR_PENALTY);
                end
            end
            STALL: begin
                if (dhs) begin
                    if (!b_d) begin
                        state_d = FLUSH;
                        pen_d   = PEN_W'(BR_PENALTY);
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            FLUSH: begin
                if (dhs) begin
                    if (pen_q <= PEN_W'(1)) begin
                        state_d = RUN;
                    end else begin
                        pen_d = pen_q - PEN_W'(1);
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_en  = 1'b1;
        ir_en  = 1'b1;
        bubble = 1'b0;
        flush  = 1'b0;
        if (!rst) begin
            if (!dhs) begin
                pc_en  = 1'b0;
                ir_en  = 1'b0;
                bubble = 1'b1;
            end else if (state_q == FLUSH) begin
                flush = 1'b1;
            end
        end
    end

    // Run-length of consecutive hazard cycles; a hazard seen in FLUSH is not a stall run
    assign run_en  = !dhs && (state_q != FLUSH);
    assign run_clr = dhs || (state_q == FLUSH);

    sat_counter #(
        .W(RUN_CNT_W)
    ) u_run_cnt (
        .clk(clk),
        .rst(rst),
        .clr(run_clr),
        .en (run_en),
        .cnt(run_q)
    );

    assign run_inc = (&run_q) ? run_q : run_q + RUN_CNT_W'(1);
    assign err_set = run_en && (run_inc >= RUN_CNT_W'(MAX_STALL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign stall_err = err_q;
    assign state     = state_q;

`ifdef PERF_CNT_EN
    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk(clk),
        .rst(rst),
        .clr(1'b0),
        .en (bubble),
        .cnt(stall_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk(clk),
        .rst(rst),
        .clr(1'b0),
        .en (flush),
        .cnt(flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with BR_PENALTY=2, MAX_STALL=4.
module tb_pipe_stall_ctrl;

    localparam int unsigned BR_PEN = 2;
    localparam int unsigned MAX_ST = 4;
    localparam int unsigned CW     = 16;
`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dhs = 1'b1;
    logic          b_d = 1'b1;
    logic          pc_en, ir_en, bubble, flush, stall_err;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned exp_sc   = 0;
    int unsigned exp_fc   = 0;
    logic        exp_err  = 1'b0;

    pipe_stall_ctrl #(
        .BR_PENALTY(BR_PEN),
        .MAX_STALL (MAX_ST),
        .CNT_W     (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .dhs      (dhs),
        .b_d      (b_d),
        .pc_en    (pc_en),
        .ir_en    (ir_en),
        .bubble   (bubble),
        .flush    (flush),
        .stall_err(stall_err),
        .state    (state),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cnts(input string tag);
        check({tag, ".stall_cnt"}, 32'(stall_cnt), PERF ? exp_sc : 32'd0);
        check({tag, ".flush_cnt"}, 32'(flush_cnt), PERF ? exp_fc : 32'd0);
    endtask

    // One clock: apply inputs after the edge, check the Mealy outputs mid-cycle
    task automatic cyc(input string tag, input logic d, input logic b,
                       input logic e_pc, input logic e_ir, input logic e_bub,
                       input logic e_fl, input logic [1:0] e_st);
        @(posedge clk);
        #1;
        dhs = d;
        b_d = b;
        @(negedge clk);
        check({tag, ".pc_en"},     32'(pc_en),     32'(e_pc));
        check({tag, ".ir_en"},     32'(ir_en),     32'(e_ir));
        check({tag, ".bubble"},    32'(bubble),    32'(e_bub));
        check({tag, ".flush"},     32'(flush),     32'(e_fl));
        check({tag, ".state"},     32'(state),     32'(e_st));
        check({tag, ".stall_err"}, 32'(stall_err), 32'(exp_err));
        check_cnts(tag);
        if (e_bub) exp_sc++;
        if (e_fl)  exp_fc++;
    endtask

    initial begin
        // During reset: outputs forced to pass-through even with a hazard on dhs
        #2;
        dhs = 1'b0;
        #1;
        check("rst.pc_en",  32'(pc_en),  32'd1);
        check("rst.ir_en",  32'(ir_en),  32'd1);
        check("rst.bubble", 32'(bubble), 32'd0);
        check("rst.flush",  32'(flush),  32'd0);
        check("rst.state",  32'(state),  32'd0);
        check("rst.err",    32'(stall_err), 32'd0);
        check_cnts("rst");
        dhs = 1'b1;
        #19;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) cyc("idle", 1, 1, 1, 1, 0, 0, 2'b00);

        cyc("hz1.c0", 0, 1, 0, 0, 1, 0, 2'b00);
        cyc("hz1.c1", 1, 1, 1, 1, 0, 0, 2'b01);
        cyc("hz1.c2", 1, 1, 1, 1, 0, 0, 2'b00);

        cyc("br.c0", 1, 0, 1, 1, 0, 0, 2'b00);
        cyc("br.c1", 1, 1, 1, 1, 0, 1, 2'b10);
        cyc("br.c2", 1, 0, 1, 1, 0, 1, 2'b10);
        cyc("br.c3", 1, 1, 1, 1, 0, 0, 2'b00);

        // Hazard inside FLUSH holds the penalty
        cyc("brh.c0", 1, 0, 1, 1, 0, 0, 2'b00);
        cyc("brh.c1", 0, 1, 0, 0, 1, 0, 2'b10);
        cyc("brh.c2", 1, 1, 1, 1, 0, 1, 2'b10);
        cyc("brh.c3", 1, 1, 1, 1, 0, 1, 2'b10);
        cyc("brh.c4", 1, 1, 1, 1, 0, 0, 2'b00);

        cyc("hzbr.c0", 0, 0, 0, 0, 1, 0, 2'b00);
        cyc("hzbr.c1", 0, 0, 0, 0, 1, 0, 2'b01);
        cyc("hzbr.c2", 1, 0, 1, 1, 0, 0, 2'b01);
        cyc("hzbr.c3", 1, 1, 1, 1, 0, 1, 2'b10);
        cyc("hzbr.c4", 1, 1, 1, 1, 0, 1, 2'b10);
        cyc("hzbr.c5", 1, 1, 1, 1, 0, 0, 2'b00);

        // stall_err is set on the 4th edge of a continuous hazard
        cyc("long.c1", 0, 1, 0, 0, 1, 0, 2'b00);
        cyc("long.c2", 0, 1, 0, 0, 1, 0, 2'b01);
        cyc("long.c3", 0, 1, 0, 0, 1, 0, 2'b01);
        cyc("long.c4", 0, 1, 0, 0, 1, 0, 2'b01);
        exp_err = 1'b1;
        cyc("long.c5", 0, 1, 0, 0, 1, 0, 2'b01);
        cyc("long.c6", 0, 1, 0, 0, 1, 0, 2'b01);
        cyc("long.c7", 1, 1, 1, 1, 0, 0, 2'b01);
        cyc("long.c8", 1, 1, 1, 1, 0, 0, 2'b00);

        cyc("rstf.c0", 1, 0, 1, 1, 0, 0, 2'b00);
        cyc("rstf.c1", 1, 1, 1, 1, 0, 1, 2'b10);
        rst = 1'b1;
        #1;
        exp_sc  = 0;
        exp_fc  = 0;
        exp_err = 1'b0;
        check("rstf.pc_en",  32'(pc_en),  32'd1);
        check("rstf.flush",  32'(flush),  32'd0);
        check("rstf.bubble", 32'(bubble), 32'd0);
        check("rstf.state",  32'(state),  32'd0);
        check("rstf.err",    32'(stall_err), 32'd0);
        check_cnts("rstf");
        @(negedge clk);
        rst = 1'b0;
        cyc("rstf.c2", 1, 1, 1, 1, 0, 0, 2'b00);
        cyc("rstf.c3", 1, 1, 1, 1, 0, 0, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
